// File: rtl/ntt_twiddle_stream_gen.sv
// NTT twiddle streamer: per stage emits w_s^0..w_s^(2^s-1); the first SEED powers come
// from ROM, later ones as x_j = x_(j-SEED) * w_s^SEED through the shared modular multiplier.
module ntt_twiddle_stream_gen #(
  parameter int LOG_N_MAX      = 13,
  parameter int W              = 54,
  parameter int SEED           = 16,
  parameter int MUL_LAT        = 14,
  parameter int ROM_LAT        = 1,
  parameter int ADDR_WIDTH_ROM = 9,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                log_n,
  input  logic                      inverse,
  input  logic [ADDR_WIDTH_ROM-1:0] rom_base,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_WIDTH_ROM-1:0] rom_addr,
  output logic                      rom_en,
  input  logic [W-1:0]              rom_data,
  output logic                      mult_valid,
  output logic [W-1:0]              mult_a,
  output logic [W-1:0]              mult_b,
  input  logic [W-1:0]              mult_result,
  output logic [W-1:0]              tw_ntt,
  output logic [3:0]                tw_stage,
  output logic                      tw_last_stage,
  output logic                      tw_last,
  output logic                      tw_valid,
  input  logic                      tw_ready
);
  localparam int L      = ROM_LAT + MUL_LAT;
  localparam int KW     = LOG_N_MAX;
  localparam int HW     = (SEED > 1) ? $clog2(SEED) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int IW     = $clog2(L + 1);
  localparam int STRIDE = SEED + 1;
  localparam int REGION = LOG_N_MAX * STRIDE;
  localparam int TW     = W + 6;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_WC, S_SEED_PH, S_MUL_PH, S_NEXT, S_FINISH} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                s_q, s_d, log_n_q, log_n_d;
  logic [KW-1:0]             k_q, k_d;
  logic                      inv_q, inv_d, bank_q, bank_d;
  logic [ADDR_WIDTH_ROM-1:0] base_q, base_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [KW-1:0]             stage_len_m1, seed_end;
  logic                      big_stage, final_stage, can_issue;
  logic [ADDR_WIDTH_ROM-1:0] entry_base;
  logic                      issue, issue_mul, wc_load, tag_ls;

  // Issue-to-FIFO tag pipeline, L deep, shared by ROM and multiplier paths
  logic [L:1]        pv_q, pmul_q, pls_q, plast_q;
  logic [3:0]        pstage_q [1:L];
  logic [HW-1:0]     phidx_q  [1:L];
  logic [ROM_LAT:1]  wcv_q, wcb_q, mv_q, mb_q;
  logic [W-1:0]      hist_rd_q [1:ROM_LAT];
  logic [W-1:0]      rdly_q    [1:MUL_LAT];
  logic [W-1:0]      w_c_q     [2];
  logic [W-1:0]      hist_mem  [SEED];
  logic [TW-1:0]     fifo_mem  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [IW-1:0]     inflight_q;
  logic              fifo_wr, fifo_rd;
  logic [W-1:0]      fifo_wdata;
  logic [TW-1:0]     fifo_head;

  always_comb begin
    stage_len_m1 = (KW'(1) << s_q) - KW'(1);
    big_stage    = stage_len_m1 >= KW'(SEED);
    seed_end     = big_stage ? KW'(SEED - 1) : stage_len_m1;
    final_stage  = inv_q ? (s_q == 4'd0) : (s_q == log_n_q - 4'd1);
    can_issue    = (32'(fifo_cnt_q) + 32'(inflight_q)) < FIFO_DEPTH;
    entry_base   = base_q + ADDR_WIDTH_ROM'(inv_q ? REGION : 0)
                 + ADDR_WIDTH_ROM'(32'(s_q) * STRIDE);
    tag_ls       = (k_q == stage_len_m1);
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    k_d       = k_q;
    log_n_d   = log_n_q;
    inv_d     = inv_q;
    base_d    = base_q;
    bank_d    = bank_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    issue     = 1'b0;
    issue_mul = 1'b0;
    wc_load   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (log_n != 4'd0 && 32'(log_n) <= LOG_N_MAX) begin
          busy_d  = 1'b1;
          log_n_d = log_n;
          inv_d   = inverse;
          base_d  = rom_base;
          s_d     = inverse ? log_n - 4'd1 : 4'd0;
          state_d = S_LOAD_WC;
        end else begin
          err_d = 1'b1;
        end
      end
      S_LOAD_WC: begin
        // w_s^SEED goes to the idle bank so older multiplies keep their own constant
        if (big_stage) begin
          rom_en   = 1'b1;
          rom_addr = entry_base + ADDR_WIDTH_ROM'(SEED);
          wc_load  = 1'b1;
          bank_d   = ~bank_q;
        end
        k_d     = '0;
        state_d = S_SEED_PH;
      end
      S_SEED_PH: if (can_issue) begin
        rom_en   = 1'b1;
        rom_addr = entry_base + ADDR_WIDTH_ROM'(k_q);
        issue    = 1'b1;
        k_d      = k_q + KW'(1);
        if (k_q == seed_end) state_d = big_stage ? S_MUL_PH : S_NEXT;
      end
      S_MUL_PH: if (can_issue) begin
        issue     = 1'b1;
        issue_mul = 1'b1;
        k_d       = k_q + KW'(1);
        if (tag_ls) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (final_stage) begin
          state_d = S_FINISH;
        end else begin
          s_d     = inv_q ? s_q - 4'd1 : s_q + 4'd1;
          state_d = S_LOAD_WC;
        end
      end
      S_FINISH: if (fifo_cnt_q == '0 && inflight_q == '0) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      log_n_q <= '0;
      inv_q   <= 1'b0;
      base_q  <= '0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      log_n_q <= log_n_d;
      inv_q   <= inv_d;
      base_q  <= base_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fifo_wr    = pv_q[L];
  assign fifo_wdata = pmul_q[L] ? mult_result : rdly_q[MUL_LAT];
  assign tw_valid   = (fifo_cnt_q != '0);
  assign fifo_rd    = tw_valid & tw_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q       <= '0;
      pmul_q     <= '0;
      pls_q      <= '0;
      plast_q    <= '0;
      wcv_q      <= '0;
      wcb_q      <= '0;
      mv_q       <= '0;
      mb_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
    end else begin
      pv_q[1]    <= issue;
      pmul_q[1]  <= issue_mul;
      pls_q[1]   <= tag_ls;
      plast_q[1] <= tag_ls & final_stage;
      for (int i = 2; i <= L; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pmul_q[i]  <= pmul_q[i-1];
        pls_q[i]   <= pls_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
      wcv_q[1] <= wc_load;
      wcb_q[1] <= ~bank_q;
      mv_q[1]  <= issue_mul;
      mb_q[1]  <= bank_q;
      for (int i = 2; i <= ROM_LAT; i++) begin
        wcv_q[i] <= wcv_q[i-1];
        wcb_q[i] <= wcb_q[i-1];
        mv_q[i]  <= mv_q[i-1];
        mb_q[i]  <= mb_q[i-1];
      end
      if (fifo_wr) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (fifo_rd) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
      inflight_q <= inflight_q + IW'(issue) - IW'(fifo_wr);
    end
  end

  // Data-only storage; the reset-cleared valid bits above decide what is ever used
  always_ff @(posedge clk) begin
    pstage_q[1] <= s_q;
    phidx_q[1]  <= k_q[HW-1:0];
    for (int i = 2; i <= L; i++) begin
      pstage_q[i] <= pstage_q[i-1];
      phidx_q[i]  <= phidx_q[i-1];
    end
    hist_rd_q[1] <= hist_mem[k_q[HW-1:0]];
    for (int i = 2; i <= ROM_LAT; i++) hist_rd_q[i] <= hist_rd_q[i-1];
    rdly_q[1] <= rom_data;
    for (int i = 2; i <= MUL_LAT; i++) rdly_q[i] <= rdly_q[i-1];
    if (wcv_q[ROM_LAT]) w_c_q[wcb_q[ROM_LAT]] <= rom_data;
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q]       <= {plast_q[L], pls_q[L], pstage_q[L], fifo_wdata};
      hist_mem[phidx_q[L]]     <= fifo_wdata;
    end
  end

  assign fifo_head     = fifo_mem[rd_ptr_q];
  assign tw_ntt        = tw_valid ? fifo_head[W-1:0] : '0;
  assign tw_stage      = tw_valid ? fifo_head[W+3:W] : 4'd0;
  assign tw_last_stage = tw_valid & fifo_head[W+4];
  assign tw_last       = tw_valid & fifo_head[W+5];

  assign mult_valid = mv_q[ROM_LAT];
  assign mult_a     = mult_valid ? hist_rd_q[ROM_LAT] : '0;
  assign mult_b     = mult_valid ? w_c_q[mb_q[ROM_LAT]] : '0;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_ntt_twiddle_stream_gen.sv
// Bench for ntt_twiddle_stream_gen: ROM and modular-multiplier models (q=7681), a scoreboard
// of golden w_s^j values, and a negedge monitor that checks every output handshake.
module tb_ntt_twiddle_stream_gen;
  localparam int LOG_N_MAX = 13, W = 54, SEED = 16, MUL_LAT = 14, ROM_LAT = 1;
  localparam int AW = 9, FIFO_DEPTH = 32;
  localparam int STRIDE = SEED + 1, REGION = LOG_N_MAX * STRIDE;
  localparam longint Q = 7681;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   stage;
    logic         ls;
    logic         last;
  } sb_item_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, inverse = 1'b0, tw_ready = 1'b1;
  logic [3:0]    log_n = '0;
  logic [AW-1:0] rom_base = '0, cur_base = '0;
  logic          busy, done, err, rom_en, mult_valid;
  logic          tw_last_stage, tw_last, tw_valid;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data = '0, mult_a, mult_b, mult_result, tw_ntt;
  logic [3:0]    tw_stage;

  int checks = 0, errors = 0;
  int mult_cnt = 0, done_cnt = 0, err_cnt = 0, out_idx = 0;
  bit busy_seen = 0, throttle = 0;
  int rdy_phase = 0;
  int rom_log[$];
  sb_item_t sb[$];
  sb_item_t mon_exp, mon_got;

  ntt_twiddle_stream_gen #(
    .LOG_N_MAX(LOG_N_MAX), .W(W), .SEED(SEED), .MUL_LAT(MUL_LAT), .ROM_LAT(ROM_LAT),
    .ADDR_WIDTH_ROM(AW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .log_n(log_n), .inverse(inverse),
    .rom_base(rom_base), .busy(busy), .done(done), .err(err), .rom_addr(rom_addr),
    .rom_en(rom_en), .rom_data(rom_data), .mult_valid(mult_valid), .mult_a(mult_a),
    .mult_b(mult_b), .mult_result(mult_result), .tw_ntt(tw_ntt), .tw_stage(tw_stage),
    .tw_last_stage(tw_last_stage), .tw_last(tw_last), .tw_valid(tw_valid), .tw_ready(tw_ready)
  );

  always #5 clk = ~clk;

  // Arbitrary per-stage bases: only consistency between ROM powers and the golden matters
  function automatic longint base_of(input bit inv, input int s);
    return inv ? longint'(2000 + 7 * s) : longint'(3 + 11 * s);
  endfunction

  function automatic longint powmod(input longint g, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * g) % Q;
    return r;
  endfunction

  function automatic longint rom_val(input logic [AW-1:0] a);
    int off;
    bit inv;
    off = (int'(a) - int'(cur_base) + 512) % 512;
    inv = (off >= REGION);
    if (inv) off = off - REGION;
    return powmod(base_of(inv, off / STRIDE), off % STRIDE);
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= W'(rom_val(rom_addr));

  logic [W-1:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mult_valid ? W'((longint'(mult_a) * longint'(mult_b)) % Q) : '0;
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_result = mpipe[MUL_LAT-1];

  initial forever begin
    @(posedge clk);
    #1;
    rdy_phase = (rdy_phase + 1) % 3;
    tw_ready  = throttle ? (rdy_phase == 0) : 1'b1;
  end

  always @(negedge clk) if (rst_n) begin
    if (rom_en) rom_log.push_back(int'(rom_addr));
    if (mult_valid) mult_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy) busy_seen = 1;
    if (tw_valid && tw_ready) begin
      mon_got = {tw_ntt, tw_stage, tw_last_stage, tw_last};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got value=%0d stage=%0d, required no output",
                 tw_ntt, tw_stage);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL tw_out[%0d]: got v=%0d s=%0d ls=%0d last=%0d, required v=%0d s=%0d ls=%0d last=%0d",
                   out_idx, mon_got.data, mon_got.stage, mon_got.ls, mon_got.last,
                   mon_exp.data, mon_exp.stage, mon_exp.ls, mon_exp.last);
        end else begin
          $display("tw_out[%0d]: v=%0d s=%0d ls=%0d last=%0d ok",
                   out_idx, mon_got.data, mon_got.stage, mon_got.ls, mon_got.last);
        end
      end
      out_idx++;
    end
  end

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("check %s: %0d ok", name, got);
    end
  endtask

  task automatic clear_logs();
    rom_log.delete();
    mult_cnt  = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    busy_seen = 0;
    out_idx   = 0;
  endtask

  task automatic push_expected(input int ln, input bit inv);
    int s;
    longint g;
    sb_item_t it;
    for (int t = 0; t < ln; t++) begin
      s = inv ? ln - 1 - t : t;
      g = base_of(inv, s);
      for (int j = 0; j < (1 << s); j++) begin
        it.data  = W'(powmod(g, j));
        it.stage = 4'(s);
        it.ls    = (j == (1 << s) - 1);
        it.last  = it.ls && (t == ln - 1);
        sb.push_back(it);
      end
    end
  endtask

  task automatic pulse_start(input int ln, input bit inv, input int base);
    cur_base = AW'(base);
    @(posedge clk);
    #1;
    log_n    = 4'(ln);
    inverse  = inv;
    rom_base = AW'(base);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, longint'(done_cnt != 0), 1);
    repeat (5) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_busy_after"}, longint'(busy), 0);
    check({name, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, longint'(|{busy, done, err, rom_en, rom_addr, mult_valid, mult_a, mult_b,
                            tw_valid, tw_ntt, tw_stage, tw_last_stage, tw_last}), 0);
  endtask

  initial begin
    int exp_addr [7];
    int n;
    exp_addr = '{0, 17, 18, 34, 35, 36, 37};

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Small forward set: pure ROM path
    clear_logs();
    push_expected(3, 0);
    pulse_start(3, 0, 0);
    wait_done("fwd3");
    check("fwd3_rom_reads", rom_log.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < rom_log.size()) check($sformatf("fwd3_rom_addr[%0d]", i), rom_log[i], exp_addr[i]);
    check("fwd3_mult_pulses", mult_cnt, 0);

    // log_n=6 forward: stage 5 mixes ROM and multiplier values
    clear_logs();
    push_expected(6, 0);
    pulse_start(6, 0, 0);
    wait_done("fwd6");
    check("fwd6_mult_pulses", mult_cnt, 16);
    check("fwd6_rom_reads", rom_log.size(), 48);
    if (rom_log.size() > 31) check("fwd6_wc_addr", rom_log[31], 5 * STRIDE + SEED);

    // Same set under 1-in-3 backpressure
    clear_logs();
    throttle = 1;
    push_expected(6, 0);
    pulse_start(6, 0, 0);
    wait_done("fwd6_bp");
    throttle = 0;
    check("fwd6_bp_mult_pulses", mult_cnt, 16);

    // Inverse with a non-zero base
    clear_logs();
    push_expected(5, 1);
    pulse_start(5, 1, 129);
    wait_done("inv5");
    check("inv5_rom_reads", rom_log.size(), 31);
    if (rom_log.size() > 0) check("inv5_first_addr", rom_log[0], 418);
    check("inv5_mult_pulses", mult_cnt, 0);

    // Illegal sizes
    clear_logs();
    pulse_start(0, 0, 0);
    repeat (3) @(negedge clk);
    check("err_logn0", err_cnt, 1);
    pulse_start(14, 0, 0);
    repeat (3) @(negedge clk);
    check("err_logn14", err_cnt, 2);
    check("err_busy_seen", longint'(busy_seen), 0);
    check("err_rom_reads", rom_log.size(), 0);

    // Asynchronous reset inside stage 5, then a clean rerun
    clear_logs();
    push_expected(6, 0);
    pulse_start(6, 0, 0);
    n = 0;
    while (mult_cnt < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reached_stage5", longint'(mult_cnt >= 4), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset_outputs");
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    push_expected(6, 0);
    pulse_start(6, 0, 0);
    wait_done("rerun6");
    check("rerun6_mult_pulses", mult_cnt, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
